axi4lite_s_mem: RTL and testbench
=================================

# axi4lite_s_mem

Synthesizable AXI4-Lite slave memory. It terminates one AXI4-Lite master port and provides a parametrised, byte-strobed word memory. Address range checking returns SLVERR, and read latency is programmable. It sits opposite the master-side interface in block benches and serves as a default target in subsystem integration.

## Interface
Parameters:
- DATA_W, 128, data bus width in bits; one of 32, 64, 128; strobe width is DATA_W/8
- ADDR_W, 32, address width in bits
- DEPTH, 256, number of DATA_W words; power of two, at least 2
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_W/8
- RD_LAT, 1, cycles from the AR handshake edge to rvalid rising; range 1–8

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready

## Operation
- Word index = (addr − BASE_ADDR) >> log2(DATA_W/8). Low address bits are ignored, so no alignment error exists.
- An address is in range when BASE_ADDR ≤ addr < BASE_ADDR + DEPTH*DATA_W/8. Otherwise the response is SLVERR (2'b10).
- Write FSM states:
  - WR_IDLE: awready=1, wready=1.
  - WR_NEED_W: AW captured; awready=0, wready=1.
  - WR_NEED_AW: W captured; awready=1, wready=0.
  - WR_RESP: bvalid=1.
- Write FSM transitions:
  - WR_IDLE goes to WR_RESP when AW and W handshake on the same edge.
  - WR_IDLE goes to WR_NEED_W when only AW handshakes.
  - WR_IDLE goes to WR_NEED_AW when only W handshakes.
  - Either NEED state goes to WR_RESP when the missing beat handshakes.
  - WR_RESP goes to WR_IDLE on bvalid&&bready.
- Write commit: on the edge that enters WR_RESP, bytes with wstrb[i]=1 are written; bytes with wstrb[i]=0 are unchanged.
- An out-of-range write does not modify memory. bresp=SLVERR; otherwise bresp=OKAY (2'b00).
- wstrb=0 in range: no bytes change; bresp=OKAY.
- Read FSM states:
  - RD_IDLE: arready=1.
  - RD_WAIT: latency counter runs.
  - RD_DATA: rvalid=1.
- Read FSM transitions:
  - RD_IDLE goes to RD_WAIT on an AR handshake. With RD_LAT=1 it goes directly to RD_DATA.
  - RD_WAIT goes to RD_DATA when the counter reaches RD_LAT−1.
  - RD_DATA goes to RD_IDLE on rvalid&&rready.
- Read data is sampled from memory on the edge rvalid rises. It is held stable, together with rresp, until the R handshake.
- An out-of-range read returns rdata=0 and rresp=SLVERR.
- The write and read channels are fully independent and may be active concurrently.

## Timing
- Reset values, with rst_n=0 sampled at an edge:
  - awready=0, wready=0, arready=0
  - bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0
  - FSMs enter WR_IDLE and RD_IDLE; readies rise on the first edge with rst_n=1.
  - Memory contents are not reset.
- Write latency: the final AW/W handshake at edge N gives bvalid=1 after N. If bready=1, the B handshake occurs at N+1 and awready/wready are high after N+1.
- Read latency: the AR handshake at edge N gives rvalid=1 after edge N+RD_LAT−1. arready stays low from N until the edge after the R handshake.
- Valid outputs never drop without their handshake; bresp/rresp/rdata do not change while valid is high.
- Same-address read/write collision: if the read data sample edge equals the write commit edge, the read returns the old data.
- rst_n low mid-transaction aborts it at that edge: no memory write occurs if WR_RESP has not yet been entered, and all outputs return to reset values.

## Structure
- Shared package axi4lite_pkg:
  - resp enum: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11
  - wr_state_t and rd_state_t enums
- Sub-module axi4lite_s_mem_array: single-clock, DEPTH × DATA_W, byte-write-enabled, one write port and one read port, synchronous read, read-before-write.
- Top level holds both FSMs, the range check, the RD_LAT counter and the capture registers.

## Test plan
- Write followed by read: AW and W in the same cycle with addr 0x10, wdata=128'hA5…A5, wstrb=16'hFFFF; then read addr 0x10.
  - Required: bresp=00, rdata=A5…A5, rresp=00.
  - Required: rvalid rises exactly RD_LAT cycles after AR (sweep RD_LAT=1,4).
- W before AW: W beat 3 cycles before AW.
  - Required: bvalid one cycle after AW; wready=0 while waiting.
- Partial strobe: fill word 0 with 0xFF bytes, then write 0x00 with wstrb=16'h000F.
  - Required: readback shows low 4 bytes 0x00 and the rest 0xFF.
- Out of range: write and read at BASE_ADDR + DEPTH*16.
  - Required: bresp=10, rresp=10, rdata=0.
  - Required: a prior readback of word 0 is unchanged.
- Backpressure: hold bready and rready low for 5 cycles.
  - Required: bvalid/rvalid and their data stay stable; awready, wready and arready stay low.
- Reset mid-write: AW accepted, rst_n low before W.
  - Required: readies are 0 during reset; the target word is unchanged afterwards; a new write completes normally.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite slave memory: response codes and FSM state encodings.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_NEED_W  = 2'd1,
    WR_NEED_AW = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  // Wide enough for RD_LAT up to 8 (counter tops out at RD_LAT-1).
  localparam int RD_CNT_W = 4;

  function automatic logic [1:0] resp_of(input logic in_rng);
    return in_rng ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi4lite_s_mem_array.sv
// DEPTH x DATA_W word memory with per-byte write enables and a registered,
// read-before-write read port.
module axi4lite_s_mem_array #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read and write share one process so a same-edge collision returns the old word.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[rd_idx];
    for (int i = 0; i < STRB_W; i++) begin
      if (we && wstrb[i]) mem[wr_idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi4lite_s_mem.sv
// AXI4-Lite slave memory: independent write and read FSMs in front of a byte-strobed
// word array, with address range checking (SLVERR) and programmable read latency.
module axi4lite_s_mem
  import axi4lite_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * STRB_W);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  wr_state_t            wr_state_q, wr_state_d;
  rd_state_t            rd_state_q, rd_state_d;
  logic                 rdy_en_q, rdy_en_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [RD_CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]    awaddr_q, awaddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]    wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]    araddr_q, araddr_d;

  logic                 aw_hs, w_hs, ar_hs;
  logic                 wr_commit, wr_ok, mem_we;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [STRB_W-1:0]    wr_strb;
  logic                 rd_sample;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_W-1:0]    arr_rdata;

  // Readies stay low until the first edge after reset is released.
  assign rdy_en_d = 1'b1;

  always_comb begin
    wr_state_d = wr_state_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        awready = rdy_en_q;
        wready  = rdy_en_q;
      end
      WR_NEED_W:  wready  = rdy_en_q;
      WR_NEED_AW: awready = rdy_en_q;
      WR_RESP:    bvalid  = 1'b1;
      default: ;
    endcase
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = WR_RESP;
        else if (aw_hs)    wr_state_d = WR_NEED_W;
        else if (w_hs)     wr_state_d = WR_NEED_AW;
      end
      WR_NEED_W:  if (w_hs)   wr_state_d = WR_RESP;
      WR_NEED_AW: if (aw_hs)  wr_state_d = WR_RESP;
      WR_RESP:    if (bready) wr_state_d = WR_IDLE;
      default:    wr_state_d = WR_IDLE;
    endcase
  end

  // Commit uses whichever beat arrives on the final edge and the captured copy of the other.
  always_comb begin
    wr_commit = (wr_state_d == WR_RESP) && (wr_state_q != WR_RESP);
    wr_addr   = (wr_state_q == WR_NEED_W)  ? awaddr_q : awaddr;
    wr_data   = (wr_state_q == WR_NEED_AW) ? wdata_q  : wdata;
    wr_strb   = (wr_state_q == WR_NEED_AW) ? wstrb_q  : wstrb;
    wr_ok     = in_range(wr_addr);
    mem_we    = wr_commit && wr_ok && rst_n;
    bresp_d   = wr_commit ? resp_of(wr_ok) : bresp_q;
    awaddr_d  = aw_hs ? awaddr : awaddr_q;
    wdata_d   = w_hs  ? wdata  : wdata_q;
    wstrb_d   = w_hs  ? wstrb  : wstrb_q;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    arready    = rdy_en_q && (rd_state_q == RD_IDLE);
    rvalid     = (rd_state_q == RD_DATA);
    ar_hs      = arvalid && arready;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = (RD_LAT == 1) ? RD_DATA : RD_WAIT;
          rd_cnt_d   = RD_CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == RD_CNT_W'(RD_LAT - 1)) rd_state_d = RD_DATA;
        else                                   rd_cnt_d   = rd_cnt_q + RD_CNT_W'(1);
      end
      RD_DATA: if (rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // The array is sampled on the edge rvalid rises; with RD_LAT=1 that is the AR edge itself.
  always_comb begin
    rd_sample = (rd_state_d == RD_DATA) && (rd_state_q != RD_DATA);
    rd_addr   = (rd_state_q == RD_IDLE) ? araddr : araddr_q;
    rresp_d   = rd_sample ? resp_of(in_range(rd_addr)) : rresp_q;
    araddr_d  = ar_hs ? araddr : araddr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      rdy_en_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      rd_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      rdy_en_q   <= rdy_en_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
    araddr_q <= araddr_d;
  end

  axi4lite_s_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .we     (mem_we),
    .wr_idx (word_idx(wr_addr)),
    .wstrb  (wr_strb),
    .wdata  (wr_data),
    .re     (rd_sample),
    .rd_idx (word_idx(rd_addr)),
    .rdata  (arr_rdata)
  );

  assign bresp = bresp_q;
  assign rresp = rresp_q;
  // Error responses and idle cycles present zero data.
  assign rdata = (rvalid && (rresp_q == OKAY)) ? arr_rdata : '0;

endmodule

// File: tb/tb_axi4lite_s_mem.sv
// Bench for axi4lite_s_mem: two instances (RD_LAT=1 and RD_LAT=4) share the write channel,
// each has its own read channel; expected responses flow through scoreboard queues.
module tb_axi4lite_s_mem;

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   resp;
  } rexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [31:0]  awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready, awready1;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready, wready1;
  logic [1:0]   bresp, bresp1;
  logic         bvalid, bvalid1;
  logic         bready = 1'b0;
  logic [31:0]  araddr [2];
  logic         arvalid [2];
  logic         arready [2];
  logic [127:0] rdata [2];
  logic [1:0]   rresp [2];
  logic         rvalid [2];
  logic         rready [2];

  int checks = 0;
  int errors = 0;
  logic [127:0] model [256];
  rexp_t rq [$];
  logic [1:0] bq [$];

  axi4lite_s_mem #(.DATA_W(128), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0])
  );

  axi4lite_s_mem #(.DATA_W(128), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .RD_LAT(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready1),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready1),
    .bresp(bresp1), .bvalid(bvalid1), .bready(bready),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1])
  );

  function automatic logic [1:0] exp_b(input logic [31:0] a);
    return (a < 32'h1000) ? 2'b00 : 2'b10;
  endfunction

  function automatic rexp_t exp_rd(input logic [31:0] a);
    rexp_t e;
    e.data = (a < 32'h1000) ? model[a[11:4]] : '0;
    e.resp = exp_b(a);
    return e;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
    if (a < 32'h1000)
      for (int i = 0; i < 16; i++)
        if (s[i]) model[a[11:4]][i*8 +: 8] = d[i*8 +: 8];
  endfunction

  function automatic bit rdy(input int ch);
    case (ch)
      0:       return awready;
      1:       return wready;
      2:       return arready[0];
      default: return arready[1];
    endcase
  endfunction

  // Returns 1ns after the edge on which the channel handshakes; caller has raised valid.
  task automatic wait_hs(input int ch);
    int n = 0;
    @(negedge clk);
    while (!rdy(ch) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(ch)) begin
      checks++; errors++;
      $display("FAIL handshake_timeout ch=%0d got ready=0 need ready=1", ch);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                          input int w_lead, input int hold, output logic [1:0] r,
                          output bit timing, output bit stable, output bit wlow);
    logic [1:0] r0;
    timing = 1; stable = 1; wlow = 1;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
    if (w_lead > 0) begin
      wvalid = 1'b1; wait_hs(1); wvalid = 1'b0;
      repeat (w_lead - 1) begin
        if (wready) wlow = 0;
        @(posedge clk); #1;
      end
      if (wready) wlow = 0;
      awvalid = 1'b1; wait_hs(0); awvalid = 1'b0;
    end else begin
      awvalid = 1'b1; wvalid = 1'b1; wait_hs(0); awvalid = 1'b0; wvalid = 1'b0;
    end
    if (!bvalid || !bvalid1) timing = 0;
    r0 = bresp;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!bvalid || bresp !== r0 || awready || wready) stable = 0;
    end
    bready = 1'b1;
    @(negedge clk);
    r = bresp;
    if (!bvalid || bresp1 !== bresp) timing = 0;
    @(posedge clk); #1;
    bready = 1'b0;
    if (!(awready && wready && awready1 && wready1)) timing = 0;
  endtask

  task automatic do_read(input int p, input logic [31:0] a, input int hold,
                         output logic [127:0] d, output logic [1:0] r, output int lat, output bit stable);
    logic [127:0] d0;
    logic [1:0] r0;
    int n;
    stable = 1;
    araddr[p] = a; arvalid[p] = 1'b1; rready[p] = 1'b0;
    wait_hs(2 + p);
    arvalid[p] = 1'b0;
    lat = 1; n = 0;
    while (!rvalid[p] && n < 20) begin
      if (arready[p]) stable = 0;
      @(posedge clk); #1;
      lat++; n++;
    end
    d0 = rdata[p]; r0 = rresp[p];
    repeat (hold) begin
      @(posedge clk); #1;
      if (!rvalid[p] || rdata[p] !== d0 || rresp[p] !== r0 || arready[p]) stable = 0;
    end
    rready[p] = 1'b1;
    @(negedge clk);
    d = rdata[p]; r = rresp[p];
    if (!rvalid[p]) stable = 0;
    @(posedge clk); #1;
    rready[p] = 1'b0;
    if (!arready[p]) stable = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready[0], arready[1], awready1, wready1} !== 6'b0) begin
      errors++; $display("FAIL reset_readies got %b need 000000", {awready, wready, arready[0], arready[1], awready1, wready1});
    end
    checks++;
    if ({bvalid, rvalid[0], rvalid[1]} !== 3'b0) begin
      errors++; $display("FAIL reset_valids got %b need 000", {bvalid, rvalid[0], rvalid[1]});
    end
    checks++;
    if ({bresp, rresp[0], rresp[1]} !== 6'b0 || rdata[0] !== '0 || rdata[1] !== '0) begin
      errors++; $display("FAIL reset_resp_data got bresp=%b rresp=%b rdata=%h need 0", bresp, rresp[0], rdata[0]);
    end
    rst_n = 1'b1;
    checks++;
    if (awready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b need 0", awready);
    end
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready[0], arready[1]} !== 4'b1111) begin
      errors++; $display("FAIL ready_after_release got %b need 1111", {awready, wready, arready[0], arready[1]});
    end
  endtask

  task automatic test_write_read();
    logic [1:0] r, eb; logic [127:0] d; rexp_t e; bit t, s, wl; int lat;
    bq.push_back(exp_b(32'h10));
    model_wr(32'h10, {16{8'hA5}}, 16'hFFFF);
    do_write(32'h10, {16{8'hA5}}, 16'hFFFF, 0, 0, r, t, s, wl);
    eb = bq.pop_front();
    checks++; if (r !== eb) begin errors++; $display("FAIL wr_bresp got %b need %b", r, eb); end
    checks++; if (!t) begin errors++; $display("FAIL wr_timing got 0 need 1"); end
    for (int p = 0; p < 2; p++) begin
      rq.push_back(exp_rd(32'h10));
      do_read(p, 32'h10, 0, d, r, lat, s);
      e = rq.pop_front();
      checks++;
      if (d !== {16{8'hA5}} || {d, r} !== {e.data, e.resp}) begin
        errors++; $display("FAIL rd_0x10_p%0d got %h/%b need %h/%b", p, d, r, e.data, e.resp);
      end
      checks++;
      if (lat != ((p == 0) ? 1 : 4)) begin
        errors++; $display("FAIL rd_latency_p%0d got %0d need %0d", p, lat, (p == 0) ? 1 : 4);
      end
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r, eb; logic [127:0] d; rexp_t e; bit t, s, wl; int lat;
    bq.push_back(exp_b(32'h20));
    model_wr(32'h20, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF);
    do_write(32'h20, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF, 3, 0, r, t, s, wl);
    eb = bq.pop_front();
    checks++; if (r !== eb) begin errors++; $display("FAIL wlead_bresp got %b need %b", r, eb); end
    checks++; if (!t) begin errors++; $display("FAIL wlead_bvalid_timing got 0 need 1"); end
    checks++; if (!wl) begin errors++; $display("FAIL wlead_wready_low got 0 need 1"); end
    rq.push_back(exp_rd(32'h20));
    do_read(0, 32'h20, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL wlead_readback got %h need %h", d, e.data); end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] r; logic [127:0] d; rexp_t e; bit t, s, wl; int lat;
    model_wr(32'h0, {16{8'hFF}}, 16'hFFFF);
    do_write(32'h0, {16{8'hFF}}, 16'hFFFF, 0, 0, r, t, s, wl);
    bq.push_back(exp_b(32'h4));
    model_wr(32'h4, '0, 16'h000F);
    do_write(32'h4, '0, 16'h000F, 0, 0, r, t, s, wl);
    checks++; if (r !== bq.pop_front()) begin errors++; $display("FAIL strb_bresp got %b need 00", r); end
    rq.push_back(exp_rd(32'h0));
    do_read(1, 32'h0, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++;
    if (d !== {{12{8'hFF}}, {4{8'h00}}} || {d, r} !== {e.data, e.resp}) begin
      errors++; $display("FAIL strb_readback got %h need %h", d, e.data);
    end
    bq.push_back(exp_b(32'h8));
    do_write(32'h8, {16{8'h11}}, 16'h0000, 0, 0, r, t, s, wl);
    checks++; if (r !== bq.pop_front()) begin errors++; $display("FAIL strb0_bresp got %b need 00", r); end
    rq.push_back(exp_rd(32'h0));
    do_read(0, 32'h0, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL strb0_unchanged got %h need %h", d, e.data); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [127:0] d; rexp_t e; bit t, s, wl; int lat;
    bq.push_back(exp_b(32'h1000));
    model_wr(32'h1000, {16{8'h5A}}, 16'hFFFF);
    do_write(32'h1000, {16{8'h5A}}, 16'hFFFF, 0, 0, r, t, s, wl);
    checks++; if (r !== bq.pop_front() || r !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b need 10", r); end
    for (int p = 0; p < 2; p++) begin
      rq.push_back(exp_rd(32'h1000));
      do_read(p, 32'h1000, 0, d, r, lat, s);
      e = rq.pop_front();
      checks++;
      if ({d, r} !== {e.data, e.resp} || r !== 2'b10 || d !== '0) begin
        errors++; $display("FAIL oor_read_p%0d got %h/%b need 0/10", p, d, r);
      end
    end
    rq.push_back(exp_rd(32'h0));
    do_read(0, 32'h0, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL oor_word0_unchanged got %h need %h", d, e.data); end
    bq.push_back(exp_b(32'hFFC));
    model_wr(32'hFFC, {16{8'h3C}}, 16'hFFFF);
    do_write(32'hFFC, {16{8'h3C}}, 16'hFFFF, 0, 0, r, t, s, wl);
    checks++; if (r !== bq.pop_front()) begin errors++; $display("FAIL last_word_bresp got %b need 00", r); end
    rq.push_back(exp_rd(32'hFF0));
    do_read(1, 32'hFF0, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL last_word_read got %h/%b need %h/%b", d, r, e.data, e.resp); end
  endtask

  task automatic test_backpressure();
    logic [1:0] r; logic [127:0] d; rexp_t e; bit t, s, wl; int lat;
    bq.push_back(exp_b(32'h50));
    model_wr(32'h50, {8{16'hBEEF}}, 16'hFFFF);
    do_write(32'h50, {8{16'hBEEF}}, 16'hFFFF, 0, 5, r, t, s, wl);
    checks++; if (r !== bq.pop_front()) begin errors++; $display("FAIL bp_bresp got %b need 00", r); end
    checks++; if (!s) begin errors++; $display("FAIL bp_write_stable got 0 need 1"); end
    for (int p = 0; p < 2; p++) begin
      rq.push_back(exp_rd(32'h50));
      do_read(p, 32'h50, 5, d, r, lat, s);
      e = rq.pop_front();
      checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL bp_read_p%0d got %h need %h", p, d, e.data); end
      checks++; if (!s) begin errors++; $display("FAIL bp_read_stable_p%0d got 0 need 1", p); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0] r; logic [127:0] d; rexp_t e; bit t, s, wl; int lat;
    model_wr(32'h30, {4{32'hCAFE_F00D}}, 16'hFFFF);
    do_write(32'h30, {4{32'hCAFE_F00D}}, 16'hFFFF, 0, 0, r, t, s, wl);
    awaddr = 32'h30; awvalid = 1'b1;
    wait_hs(0);
    awvalid = 1'b0;
    checks++; if ({awready, wready} !== 2'b01) begin errors++; $display("FAIL need_w_readies got %b need 01", {awready, wready}); end
    wdata = '0; wstrb = 16'hFFFF; wvalid = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready[0], bvalid} !== 4'b0) begin
      errors++; $display("FAIL midrst_outputs got %b need 0000", {awready, wready, arready[0], bvalid});
    end
    wvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rq.push_back(exp_rd(32'h30));
    do_read(0, 32'h30, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL midrst_word_kept got %h need %h", d, e.data); end
    bq.push_back(exp_b(32'h30));
    model_wr(32'h30, {16{8'h77}}, 16'hFFFF);
    do_write(32'h30, {16{8'h77}}, 16'hFFFF, 0, 0, r, t, s, wl);
    checks++; if (r !== bq.pop_front() || !t) begin errors++; $display("FAIL midrst_new_write got %b/%0d need 00/1", r, t); end
    rq.push_back(exp_rd(32'h30));
    do_read(1, 32'h30, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL midrst_new_read got %h need %h", d, e.data); end
  endtask

  task automatic test_collision();
    logic [1:0] r, rw; logic [127:0] d; rexp_t e; bit t, s, s2, wl; int lat;
    model_wr(32'h40, {16{8'h01}}, 16'hFFFF);
    do_write(32'h40, {16{8'h01}}, 16'hFFFF, 0, 0, r, t, s, wl);
    rq.push_back(exp_rd(32'h40));
    bq.push_back(exp_b(32'h40));
    model_wr(32'h40, {16{8'h02}}, 16'hFFFF);
    fork
      do_write(32'h40, {16{8'h02}}, 16'hFFFF, 0, 0, rw, t, s, wl);
      do_read(0, 32'h40, 0, d, r, lat, s2);
    join
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL collision_old_data got %h need %h", d, e.data); end
    checks++; if (rw !== bq.pop_front()) begin errors++; $display("FAIL collision_bresp got %b need 00", rw); end
    rq.push_back(exp_rd(32'h40));
    do_read(0, 32'h40, 0, d, r, lat, s);
    e = rq.pop_front();
    checks++; if ({d, r} !== {e.data, e.resp}) begin errors++; $display("FAIL collision_new_data got %h need %h", d, e.data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      araddr[p] = '0; arvalid[p] = 1'b0; rready[p] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_write();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
